// File: rtl/i2s_rx_16_if.sv
// Bundle of the serial I2S lines and the parallel sample side of i2s_rx_16.
// master = stream source / sample consumer, slave = the receiver itself.
interface i2s_rx_16_if;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic [15:0] sample_left;
    logic [15:0] sample_right;
    logic        sample_valid;
    logic        frame_error;
    logic        locked;

    modport master (
        output bclk, lrclk, sdata,
        input  sample_left, sample_right, sample_valid, frame_error, locked
    );

    modport slave (
        input  bclk, lrclk, sdata,
        output sample_left, sample_right, sample_valid, frame_error, locked
    );
endinterface

// File: rtl/i2s_rx_16.sv
// Standard-I2S 16-bit stereo receiver, oversampling BCLK/LRCLK/SDATA with clk.
// Optional BCLK-loss timeout enabled by defining I2S_RX_BCLK_TIMEOUT_EN.
module i2s_rx_16 #(
    parameter int TIMEOUT = 256
) (
    input logic         clk,
    input logic         rst,
    i2s_rx_16_if.slave  bus
);

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("i2s_rx_16: TIMEOUT must be at least 2");
    end

    // bit order in the synchroniser vectors: {bclk, lrclk, sdata}
    logic [2:0]  sync1_r;
    logic [2:0]  sync2_r;
    logic        bclk_d_r;
    logic        rise_en_s;
    logic        lr_s;
    logic        sd_s;
    logic        to_hit_s;

    state_t      state_r;
    logic        lr_prev_r;
    logic [4:0]  bit_cnt_r;
    logic [15:0] shift_r;
    logic [15:0] left_hold_r;
    logic        left_ok_r;
    logic        pair_pend_r;
    logic [15:0] sample_left_r;
    logic [15:0] sample_right_r;
    logic        sample_valid_r;
    logic        frame_error_r;
    logic        locked_r;

    // Two-stage synchroniser for all three serial lines plus BCLK edge history.
    // BCLK/LRCLK reset high so warm-up cannot fake a rising edge or a boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r  <= 3'b110;
            sync2_r  <= 3'b110;
            bclk_d_r <= 1'b1;
        end else begin
            sync1_r  <= {bus.bclk, bus.lrclk, bus.sdata};
            sync2_r  <= sync1_r;
            bclk_d_r <= sync2_r[2];
        end
    end

    assign rise_en_s = sync2_r[2] & ~bclk_d_r;
    assign lr_s      = sync2_r[1];
    assign sd_s      = sync2_r[0];

`ifdef I2S_RX_BCLK_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

    logic [TO_W-1:0] to_cnt_r;

    // Saturating count of clk cycles since the last BCLK rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (rise_en_s) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (to_cnt_r != TO_MAX) begin
            to_cnt_r <= to_cnt_r + TO_W'(1'b1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    assign to_hit_s = (to_cnt_r == TO_MAX) && !rise_en_s;
`else
    assign to_hit_s = 1'b0;
`endif

    // Slot tracking, deserialisation and registered output strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= HUNT;
            lr_prev_r      <= 1'b1;
            bit_cnt_r      <= 5'd0;
            shift_r        <= 16'h0000;
            left_hold_r    <= 16'h0000;
            left_ok_r      <= 1'b0;
            pair_pend_r    <= 1'b0;
            sample_left_r  <= 16'h0000;
            sample_right_r <= 16'h0000;
            sample_valid_r <= 1'b0;
            frame_error_r  <= 1'b0;
            locked_r       <= 1'b0;
        end else begin
            sample_valid_r <= 1'b0;
            frame_error_r  <= 1'b0;
            pair_pend_r    <= 1'b0;

            // The right word was completed last cycle; shift_r is stable here
            // because two rise_en pulses can never be adjacent.
            if (pair_pend_r) begin
                sample_left_r  <= left_hold_r;
                sample_right_r <= shift_r;
                sample_valid_r <= 1'b1;
                locked_r       <= 1'b1;
            end

            if (rise_en_s) begin
                lr_prev_r <= lr_s;
                if (lr_s != lr_prev_r) begin
                    // boundary edge still carries the previous slot's last bit
                    bit_cnt_r <= 5'd0;
                    state_r   <= RUN;
                    if ((state_r == RUN) && (bit_cnt_r != 5'd0) && (bit_cnt_r < 5'd16)) begin
                        frame_error_r <= 1'b1;
                        left_ok_r     <= 1'b0;
                        locked_r      <= 1'b0;
                    end
                end else if ((state_r == RUN) && (bit_cnt_r != 5'd17)) begin
                    bit_cnt_r <= bit_cnt_r + 5'd1;
                    if (bit_cnt_r < 5'd16) begin
                        shift_r <= {shift_r[14:0], sd_s};
                    end
                    if (bit_cnt_r == 5'd15) begin
                        if (!lr_s) begin
                            left_hold_r <= {shift_r[14:0], sd_s};
                            left_ok_r   <= 1'b1;
                        end else if (left_ok_r) begin
                            pair_pend_r <= 1'b1;
                            left_ok_r   <= 1'b0;
                        end
                    end
                end
            end

            if (to_hit_s) begin
                state_r   <= HUNT;
                left_ok_r <= 1'b0;
                locked_r  <= 1'b0;
            end
        end
    end

    assign bus.sample_left  = sample_left_r;
    assign bus.sample_right = sample_right_r;
    assign bus.sample_valid = sample_valid_r;
    assign bus.frame_error  = frame_error_r;
    assign bus.locked       = locked_r;

endmodule

// File: tb/tb_i2s_rx_16.sv
// Scoreboard bench for i2s_rx_16: a slot-level reference model queues expected
// strobes while a forked monitor pops and compares every strobe the DUT emits.
module tb_i2s_rx_16;
`ifdef I2S_RX_BCLK_TIMEOUT_EN
    localparam int TO = 64;
`else
    localparam int TO = 256;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    i2s_rx_16_if bus ();

    i2s_rx_16 #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          fe;
        logic [15:0] l;
        logic [15:0] r;
        bit          lk;
    } ev_t;

    ev_t         exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // slot-level reference state
    bit          m_run;
    bit          m_prev;
    int          m_cnt;
    bit          m_left_ok;
    bit          m_locked;
    logic [15:0] m_left;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run     = 1'b0;
        m_prev    = 1'b1;
        m_cnt     = 0;
        m_left_ok = 1'b0;
        m_locked  = 1'b0;
        m_left    = 16'h0000;
    endtask

    // A slot of len BCLK rising edges on channel ch; when it opens a new slot
    // its first edge is the boundary and the next 16 edges carry the word.
    task automatic model_slot(input bit ch, input int len, input logic [15:0] word);
        int  edges;
        ev_t e;
        edges = len;
        if (ch != m_prev) begin
            if (m_run && m_cnt >= 1 && m_cnt <= 15) begin
                e = '{1'b1, 16'h0000, 16'h0000, 1'b0};
                exp_q.push_back(e);
                m_left_ok = 1'b0;
                m_locked  = 1'b0;
            end
            m_run = 1'b1;
            m_cnt = 0;
            edges = len - 1;
        end
        if (m_run) begin
            if (m_cnt < 16 && m_cnt + edges >= 16) begin
                if (!ch) begin
                    m_left    = word;
                    m_left_ok = 1'b1;
                end else if (m_left_ok) begin
                    e = '{1'b0, m_left, word, 1'b1};
                    exp_q.push_back(e);
                    m_left_ok = 1'b0;
                    m_locked  = 1'b1;
                end
            end
            m_cnt = (m_cnt + edges > 17) ? 17 : m_cnt + edges;
        end
        m_prev = ch;
    endtask

    // One BCLK period of 8 clk: data/word-select change while BCLK is low.
    task automatic send_bit(input bit lr, input bit d);
        bus.lrclk = lr;
        bus.sdata = d;
        bus.bclk  = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.bclk = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_slot(input bit ch, input int len, input logic [15:0] word, input bit pad);
        bit b;
        model_slot(ch, len, word);
        for (int e = 0; e < len; e++) begin
            if (e == 0)       b = 1'($urandom_range(0, 1));
            else if (e <= 16) b = word[16 - e];
            else              b = pad;
            send_bit(ch, b);
        end
    endtask

    initial begin
        int len;
        bus.bclk  = 1'b0;
        bus.lrclk = 1'b1;
        bus.sdata = 1'b0;
        model_reset();

        fork
            forever begin : monitor
                ev_t e;
                @(negedge clk);
                if (!rst && (bus.sample_valid || bus.frame_error)) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_strobe", {30'd0, bus.frame_error, bus.sample_valid}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("strobe_kind", {30'd0, bus.frame_error, bus.sample_valid}, e.fe ? 32'd2 : 32'd1);
                        chk("strobe_locked", {31'd0, bus.locked}, {31'd0, e.lk});
                        if (!e.fe) begin
                            chk("sample_left", {16'd0, bus.sample_left}, {16'd0, e.l});
                            chk("sample_right", {16'd0, bus.sample_right}, {16'd0, e.r});
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_left", {16'd0, bus.sample_left}, 32'd0);
        chk("rst_right", {16'd0, bus.sample_right}, 32'd0);
        chk("rst_valid", {31'd0, bus.sample_valid}, 32'd0);
        chk("rst_ferr", {31'd0, bus.frame_error}, 32'd0);
        chk("rst_locked", {31'd0, bus.locked}, 32'd0);
        rst = 1'b0;

        // partial right slot first: dropped while hunting
        send_slot(1'b1, 9, 16'h1234, 1'b0);
        repeat (3) begin
            send_slot(1'b0, 17, 16'hA55A, 1'b0);
            send_slot(1'b1, 17, 16'h0F0F, 1'b0);
        end
        chk("locked_after_frames", {31'd0, bus.locked}, {31'd0, m_locked});

        // 32-bit slots, padding must be ignored
        repeat (2) begin
            send_slot(1'b0, 33, 16'h8001, 1'b1);
            send_slot(1'b1, 33, 16'h7FFE, 1'b0);
        end

        // left slot cut to 10 bits
        send_slot(1'b0, 11, 16'h3C3C, 1'b0);
        chk("locked_before_err", {31'd0, bus.locked}, 32'd1);
        send_slot(1'b1, 17, 16'h5A5A, 1'b0);
        chk("locked_after_err", {31'd0, bus.locked}, {31'd0, m_locked});
        send_slot(1'b0, 17, 16'h1111, 1'b0);
        send_slot(1'b1, 17, 16'h2222, 1'b0);

        // random words, slot lengths and occasional short slots
        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < 2; c++) begin
                len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 16))
                                                  : int'($urandom_range(17, 33));
                send_slot(c[0], len, 16'($urandom()), 1'($urandom_range(0, 1)));
            end
        end

        // reset during the 8th bit of a right slot
        send_slot(1'b0, 17, 16'hCAFE, 1'b0);
        send_slot(1'b1, 8, 16'hBEEF, 1'b0);
        bus.sdata = 1'b1;
        bus.bclk  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_left", {16'd0, bus.sample_left}, 32'd0);
        chk("midrst_right", {16'd0, bus.sample_right}, 32'd0);
        chk("midrst_valid", {31'd0, bus.sample_valid}, 32'd0);
        chk("midrst_ferr", {31'd0, bus.frame_error}, 32'd0);
        chk("midrst_locked", {31'd0, bus.locked}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // right slot first after reset: never paired
        send_slot(1'b1, 17, 16'hDEAD, 1'b0);
        send_slot(1'b0, 17, 16'h0123, 1'b0);
        send_slot(1'b1, 17, 16'h4567, 1'b0);
        send_slot(1'b0, 17, 16'h89AB, 1'b0);
        send_slot(1'b1, 17, 16'hCDEF, 1'b0);

        // BCLK stops for 70 clk
        bus.bclk = 1'b0;
        repeat (70) @(posedge clk);
        #1;
`ifdef I2S_RX_BCLK_TIMEOUT_EN
        m_run     = 1'b0;
        m_left_ok = 1'b0;
        m_locked  = 1'b0;
`endif
        chk("locked_after_idle", {31'd0, bus.locked}, {31'd0, m_locked});
        send_slot(1'b0, 17, 16'h6B6B, 1'b0);
        send_slot(1'b1, 17, 16'h9494, 1'b0);
        send_slot(1'b0, 17, 16'hFFFF, 1'b0);
        send_slot(1'b1, 17, 16'h0001, 1'b0);

        bus.bclk = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("pending_expected", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
